if_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage.
- Holds the PC and a loadable 20-bit instruction memory, and registers one instruction per cycle onto current_instruction for decode.
- Handles stall (hold), taken-branch redirect (flush with bubble) and a halt opcode that stops fetching.

---
 rtl/if_unit.sv | 100 ++++++++++
 tb/tb_if_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit.sv
// Instruction-fetch stage: PC, loadable instruction memory and the registered
// instruction handed to decode, with stall, branch redirect and halt handling.
module if_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 20,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 20'hF0000,
  parameter logic [3:0]         HALT_OP   = 4'b1101
) (
  input  logic               clkwire,
  input  logic               rstwire_n,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] current_instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  npc_out,
  output logic               instr_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  mem [DEPTH];
  logic [INSTR_W-1:0]  fetch_word;
  logic                fetch_is_halt;

  // Combinational read at pc; registering it below gives read-before-write
  // when the same address is written on the same edge.
  assign fetch_word    = mem[pc];
  assign fetch_is_halt = (fetch_word[INSTR_W-1 -: 4] == HALT_OP);

  // NOTE: the memory array has no reset so it maps onto plain RAM and keeps
  // its program across a pipeline reset; writes are accepted even in reset.
  always_ff @(posedge clkwire) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of order.
  always_ff @(posedge clkwire) begin
    if (!rstwire_n) begin
      state               <= ST_RUN;
      pc                  <= '0;
      current_instruction <= NOP_INSTR;
      pc_out              <= '0;
      npc_out             <= ADDR_W'(1);
      instr_valid         <= 1'b0;
      halted              <= 1'b0;
      fetch_count         <= '0;
    end else if (branch_taken) begin
      // Redirect: one bubble now, the target word arrives on the next edge.
      state               <= ST_RUN;
      pc                  <= branch_target;
      current_instruction <= NOP_INSTR;
      pc_out              <= branch_target;
      npc_out             <= branch_target + ADDR_W'(1);
      instr_valid         <= 1'b0;
      halted              <= 1'b0;
    end else if (!stall_in) begin
      case (state)
        ST_RUN: begin
          current_instruction <= fetch_word;
          pc_out              <= pc;
          npc_out             <= pc + ADDR_W'(1);
          instr_valid         <= 1'b1;
          if (fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
          end
          if (fetch_is_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc + ADDR_W'(1);
          end
        end
        ST_HALT: begin
          current_instruction <= NOP_INSTR;
          instr_valid         <= 1'b0;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_unit.sv
// Scoreboard bench for if_unit: each scenario pushes the expected output
// snapshot as it drives an edge and compares it against the DUT afterwards.
module tb_if_unit;

  typedef struct packed {
    logic [19:0] instr;
    logic [7:0]  pc;
    logic [7:0]  npc;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } obs_t;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [7:0]  tgt;
    logic        we;
    logic [7:0]  waddr;
    logic [19:0] wdata;
  } stim_t;

  logic        clkwire = 1'b0;
  logic        rstwire_n;
  logic        stall_in;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [19:0] imem_wdata;
  logic [19:0] current_instruction;
  logic [7:0]  pc_out;
  logic [7:0]  npc_out;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t sb[$];

  if_unit dut (
    .clkwire             (clkwire),
    .rstwire_n           (rstwire_n),
    .stall_in            (stall_in),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .imem_we             (imem_we),
    .imem_waddr          (imem_waddr),
    .imem_wdata          (imem_wdata),
    .current_instruction (current_instruction),
    .pc_out              (pc_out),
    .npc_out             (npc_out),
    .instr_valid         (instr_valid),
    .halted              (halted),
    .fetch_count         (fetch_count)
  );

  always #5 clkwire = ~clkwire;

  function automatic obs_t mk(logic [19:0] instr, logic [7:0] pc, logic v,
                              logic h, logic [15:0] c);
    logic [7:0] npc;
    npc = pc + 8'd1;
    return '{instr, pc, npc, v, h, c};
  endfunction

  function automatic logic [19:0] fill(int i);
    logic [7:0] a;
    a = i[7:0];
    return {4'h2, 8'hA5, a};
  endfunction

  function automatic stim_t st(logic rst_n, logic stall, logic br, logic [7:0] tgt);
    return '{rst_n, stall, br, tgt, 1'b0, 8'h00, 20'h0};
  endfunction

  function automatic stim_t wr(logic rst_n, logic [7:0] addr, logic [19:0] data);
    return '{rst_n, 1'b0, 1'b0, 8'h00, 1'b1, addr, data};
  endfunction

  function automatic obs_t observe();
    return '{current_instruction, pc_out, npc_out, instr_valid, halted, fetch_count};
  endfunction

  task automatic drive(input stim_t s);
    rstwire_n     = s.rst_n;
    stall_in      = s.stall;
    branch_taken  = s.br;
    branch_target = s.tgt;
    imem_we       = s.we;
    imem_waddr    = s.waddr;
    imem_wdata    = s.wdata;
  endtask

  task automatic test_reset();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    for (int i = 0; i < 256; i++) begin
      s.push_back(wr(1'b0, 8'(i), fill(i)));
      x.push_back(mk(20'hF0000, 8'h00, 1'b0, 1'b0, 16'd0));
    end
    s.push_back(wr(1'b0, 8'h00, 20'h01230));
    s.push_back(wr(1'b0, 8'h01, 20'h10450));
    s.push_back(wr(1'b0, 8'h02, 20'h23100));
    s.push_back(wr(1'b0, 8'h03, 20'h30000));
    s.push_back(wr(1'b0, 8'h05, 20'hD0000));
    for (int i = 0; i < 5; i++) x.push_back(mk(20'hF0000, 8'h00, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  task automatic test_fetch_and_stall();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h01230, 8'h00, 1, 0, 16'd1));
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h10450, 8'h01, 1, 0, 16'd2));
    for (int i = 0; i < 3; i++) begin
      s.push_back(st(1, 1, 0, 0)); x.push_back(mk(20'h10450, 8'h01, 1, 0, 16'd2));
    end
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h23100, 8'h02, 1, 0, 16'd3));
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h30000, 8'h03, 1, 0, 16'd4));
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h2A504, 8'h04, 1, 0, 16'd5));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fetch_stall[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'hD0000, 8'h05, 1, 1, 16'd6));
    s.push_back(st(1, 1, 0, 0)); x.push_back(mk(20'hD0000, 8'h05, 1, 1, 16'd6));
    for (int i = 0; i < 4; i++) begin
      s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'hF0000, 8'h05, 0, 1, 16'd6));
    end
    s.push_back(st(1, 0, 1, 8'h00)); x.push_back(mk(20'hF0000, 8'h00, 0, 0, 16'd6));
    s.push_back(st(1, 0, 0, 0));     x.push_back(mk(20'h01230, 8'h00, 1, 0, 16'd7));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  task automatic test_branch_over_stall();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    s.push_back(st(1, 1, 1, 8'h40)); x.push_back(mk(20'hF0000, 8'h40, 0, 0, 16'd7));
    s.push_back(st(1, 0, 0, 0));     x.push_back(mk(20'h2A540, 8'h40, 1, 0, 16'd8));
    s.push_back(st(1, 0, 0, 0));     x.push_back(mk(20'h2A541, 8'h41, 1, 0, 16'd9));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch_stall[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  task automatic test_wrap_and_rbw();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    s.push_back(st(1, 0, 1, 8'hFE));          x.push_back(mk(20'hF0000, 8'hFE, 0, 0, 16'd9));
    s.push_back(st(1, 0, 0, 0));              x.push_back(mk(20'h2A5FE, 8'hFE, 1, 0, 16'd10));
    // Fetch of 0xFF while 0xFF is rewritten: the old word must come out.
    s.push_back(wr(1'b1, 8'hFF, 20'h77777));  x.push_back(mk(20'h2A5FF, 8'hFF, 1, 0, 16'd11));
    s.push_back(st(1, 0, 0, 0));              x.push_back(mk(20'h01230, 8'h00, 1, 0, 16'd12));
    s.push_back(st(1, 0, 1, 8'hFF));          x.push_back(mk(20'hF0000, 8'hFF, 0, 0, 16'd12));
    s.push_back(st(1, 0, 0, 0));              x.push_back(mk(20'h77777, 8'hFF, 1, 0, 16'd13));
    s.push_back(st(1, 0, 0, 0));              x.push_back(mk(20'h01230, 8'h00, 1, 0, 16'd14));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL wrap_rbw[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    s.push_back(st(0, 0, 0, 0)); x.push_back(mk(20'hF0000, 8'h00, 0, 0, 16'd0));
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h01230, 8'h00, 1, 0, 16'd1));
    s.push_back(st(1, 0, 0, 0)); x.push_back(mk(20'h10450, 8'h01, 1, 0, 16'd2));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    obs_t  x[$];
    obs_t  got, want;
    s.push_back(st(1, 0, 1, 8'h10)); x.push_back(mk(20'hF0000, 8'h10, 0, 0, 16'd2));
    s.push_back(st(1, 0, 1, 8'h20)); x.push_back(mk(20'hF0000, 8'h20, 0, 0, 16'd2));
    s.push_back(st(1, 0, 0, 0));     x.push_back(mk(20'h2A520, 8'h20, 1, 0, 16'd3));
    s.push_back(st(1, 0, 0, 0));     x.push_back(mk(20'h2A521, 8'h21, 1, 0, 16'd4));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(posedge clkwire); #1;
      got = observe(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h/%h/%h/%b/%b/%0d need %h/%h/%h/%b/%b/%0d", i,
                 got.instr, got.pc, got.npc, got.valid, got.halted, got.count,
                 want.instr, want.pc, want.npc, want.valid, want.halted, want.count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_and_stall();
    test_halt();
    test_branch_over_stall();
    test_wrap_and_rbw();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
